// File: rtl/apb_gpio_pad_io.sv
// Pad interface for the APB GPIO: tristate pad drive, input synchronisation with
// optional per-bit debounce and edge pulses, and external GPIO clock edge strobes.
module apb_gpio_pad_io #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [GPIO_WIDTH-1:0] out_pad_i,
  input  logic [GPIO_WIDTH-1:0] oen_padoe_i,
  inout  wire  [GPIO_WIDTH-1:0] io_pad,
  output logic [GPIO_WIDTH-1:0] in_pad_o,
  output logic [GPIO_WIDTH-1:0] in_rise_o,
  output logic [GPIO_WIDTH-1:0] in_fall_o,
  input  logic                  db_en_i,
  input  logic [DB_CNT_W-1:0]   db_limit_i,
  input  logic                  ext_clk_pad_i,
  output logic                  gpio_eclk_o,
  output logic                  eclk_rise_o,
  output logic                  eclk_fall_o
);

  logic [GPIO_WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_esync;
  logic [GPIO_WIDTH-1:0]  r_stb;
  logic [GPIO_WIDTH-1:0]  r_rise;
  logic [GPIO_WIDTH-1:0]  r_fall;
  logic [DB_CNT_W-1:0]    r_cnt [GPIO_WIDTH];
  logic                   r_eclk;
  logic                   r_eclk_rise;
  logic                   r_eclk_fall;

  logic [GPIO_WIDTH-1:0]  w_sync_last;
  logic [DB_CNT_W-1:0]    w_lim_m1;
  logic [GPIO_WIDTH-1:0]  w_stb_nxt;
  logic [DB_CNT_W-1:0]    w_cnt_nxt [GPIO_WIDTH];
  logic                   w_esync_last;

  genvar g;
  for (g = 0; g < GPIO_WIDTH; g++) begin : g_pad
    assign io_pad[g] = oen_padoe_i[g] ? out_pad_i[g] : 1'bz;
  end

  assign w_sync_last  = r_sync[SYNC_STAGES-1];
  assign w_esync_last = r_esync[SYNC_STAGES-1];

  // A limit of 0 behaves as 1, so the acceptance threshold never underflows.
  assign w_lim_m1 = (db_limit_i == '0) ? '0 : db_limit_i - DB_CNT_W'(1);

  always_comb begin
    w_stb_nxt = r_stb;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (!db_en_i) begin
        w_stb_nxt[i] = w_sync_last[i];
      end else if (w_sync_last[i] != r_stb[i]) begin
        if (r_cnt[i] >= w_lim_m1) w_stb_nxt[i] = w_sync_last[i];
        else                      w_cnt_nxt[i] = r_cnt[i] + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_esync <= '0;
    end else begin
      r_sync[0] <= io_pad;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_esync <= {r_esync[SYNC_STAGES-2:0], ext_clk_pad_i};
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_stb  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_stb  <= w_stb_nxt;
      r_rise <= w_stb_nxt & ~r_stb;
      r_fall <= ~w_stb_nxt & r_stb;
      for (int i = 0; i < GPIO_WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Strobes derive from a single level register, so rise and fall are mutually exclusive.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_eclk      <= 1'b0;
      r_eclk_rise <= 1'b0;
      r_eclk_fall <= 1'b0;
    end else begin
      r_eclk      <= w_esync_last;
      r_eclk_rise <= w_esync_last & ~r_eclk;
      r_eclk_fall <= ~w_esync_last & r_eclk;
    end
  end

  assign in_pad_o    = r_stb;
  assign in_rise_o   = r_rise;
  assign in_fall_o   = r_fall;
  assign gpio_eclk_o = r_eclk;
  assign eclk_rise_o = r_eclk_rise;
  assign eclk_fall_o = r_eclk_fall;

endmodule

// File: doc/apb_gpio_pad_io.md
Name: apb_gpio_pad_io

Overview:
Parametrised pad-interface block for the APB GPIO. It is the successor to the fixed 32-bit pad wrapper.
- Drives each bidirectional pad from the core output and its per-bit output enable.
- Synchronises the pad inputs into the pclk domain, with optional per-bit debounce and per-bit rise/fall edge pulses.
- Synchronises the external GPIO clock pad and produces edge strobes for the GPIO core.

Parameters:
GPIO_WIDTH, 32, number of pads/bits
SYNC_STAGES, 2, synchroniser flop depth (legal 2..4) for pad inputs and ext clock
DB_CNT_W, 8, debounce counter / limit width

Ports:
pclk  input  1  system clock, all flops on rising edge
presetn  input  1  synchronous active-low reset
out_pad_i  input  GPIO_WIDTH  core output data
oen_padoe_i  input  GPIO_WIDTH  per-bit output enable, 1 = pad driven by out_pad_i, 0 = pad tristated (input)
io_pad  inout  GPIO_WIDTH  bidirectional pads
in_pad_o  output  GPIO_WIDTH  synchronised (and optionally debounced) pad value
in_rise_o  output  GPIO_WIDTH  one-cycle pulse per bit on a 0->1 change of in_pad_o
in_fall_o  output  GPIO_WIDTH  one-cycle pulse per bit on a 1->0 change of in_pad_o
db_en_i  input  1  debounce enable, global
db_limit_i  input  DB_CNT_W  consecutive mismatch cycles required to accept a change
ext_clk_pad_i  input  1  external GPIO clock pad (asynchronous)
gpio_eclk_o  output  1  synchronised ext clock level
eclk_rise_o  output  1  one-cycle pulse on synchronised ext clock rising edge
eclk_fall_o  output  1  one-cycle pulse on synchronised ext clock falling edge

Behaviour:
- Pad drive, combinational and unaffected by reset:
  - io_pad[i] = out_pad_i[i] when oen_padoe_i[i]=1, else high-Z.
  - Driven bits loop back through the input path.
- Input sync: io_pad passes through SYNC_STAGES flops (s[0]..s[N-1]). Reset clears all of them to 0.
- Stable register stb (= in_pad_o), per bit, with mismatch counter cnt[i] (DB_CNT_W bits). L_eff = max(db_limit_i, 1).
  - db_en_i=0: stb <= s[N-1] every cycle; cnt held at 0.
  - db_en_i=1, s[N-1]!=stb and cnt>=L_eff-1: stb <= s[N-1], cnt <= 0.
  - db_en_i=1, s[N-1]!=stb otherwise: cnt <= cnt+1.
  - db_en_i=1, s[N-1]==stb: cnt <= 0, so a glitch shorter than L_eff is discarded.
  - db_limit_i is evaluated every cycle. Lowering it mid-count with cnt>=L_eff-1 accepts the change on that edge.
  - Toggling db_en_i 1->0 clears cnt and resumes bypass next edge.
- Latency, pad change stable before edge 1:
  - debounce off: in_pad_o updates on edge SYNC_STAGES+1.
  - debounce on: in_pad_o updates on edge SYNC_STAGES+L_eff.
- Edge pulses: registered in the same edge stb updates.
  - in_rise_o[i] = 1 for exactly that cycle when stb[i] goes 0->1; in_fall_o likewise for 1->0. Otherwise 0.
  - Bits are independent; rise and fall of different bits may coincide.
- Ext clock:
  - ext_clk_pad_i passes through SYNC_STAGES flops, then one level register gpio_eclk_o.
  - eclk_rise_o / eclk_fall_o pulse for one cycle coincident with a gpio_eclk_o change.
  - Correct operation requires ext clock high and low phases each >= SYNC_STAGES+1 pclk cycles. Faster input may drop edges, but never produces simultaneous rise and fall pulses.
- Reset (presetn=0 at an edge): in_pad_o, in_rise_o, in_fall_o, gpio_eclk_o, eclk_rise_o, eclk_fall_o, all sync flops and all counters = 0.
  - Reset mid-debounce discards the count.
  - Pads at 1 when reset releases produce a normal rise pulse once propagated.
- No internal state depends on oen_padoe_i; changing direction mid-operation only changes what the pad carries.

Test Plan:
- Reset: presetn=0 for 3 cycles with tb driving io_pad=FFFF_FFFF, oen=0 -> all outputs 0. Release -> in_pad_o=FFFF_FFFF and in_rise_o=FFFF_FFFF on edge 3 after release; in_rise_o=0 on edge 4.
- Output drive/loopback: oen=FFFF_FFFF, out=A5A5_A5A5, db_en=0 -> io_pad=A5A5_A5A5 same cycle. in_pad_o=A5A5_A5A5 on edge 3. in_rise_o=A5A5_A5A5 for one cycle.
- Mixed direction: oen=0000_FFFF, out=FFFF_FFFF, tb drives upper 16 bits 1234 -> io_pad=1234_FFFF, in_pad_o=1234_FFFF after 3 edges, no X/contention on any bit.
- Debounce: db_en=1, db_limit=4, bit0 pulsed high for 3 cycles -> in_pad_o[0] stays 0, no pulse. Held high -> in_pad_o[0]=1 on edge 6 with in_rise_o[0] one cycle. db_limit=0 -> behaves as limit 1 (edge 3).
- Reset mid-debounce: limit=8, bit5 high for 5 cycles, presetn low 1 cycle, bit5 held -> in_pad_o[5] rises on edge 10 after reset release.
- Ext clock: ext_clk_pad_i period 20 pclk -> gpio_eclk_o follows with 3-edge delay. Exactly one eclk_rise_o and one eclk_fall_o per period, never both asserted together.
